// File: rtl/rf_blackwidow_wb_writer.sv
// Writeback writer for the three-lane BlackWidow pipeline: canonicalizes each
// execute bundle and retires its register writes over two register-file ports.
package rf_blackwidow_pkg;
  typedef logic [63:0] Value;
endpackage

module rf_blackwidow_wb_writer
  import rf_blackwidow_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] xRt0,
  input  logic [5:0] xRt1,
  input  logic [5:0] xRt2,
  input  logic       xrfwr0,
  input  logic       xrfwr1,
  input  logic       xrfwr2,
  input  Value       xres0,
  input  Value       xres1,
  input  Value       xres2,
  output logic       stall_o,
  output logic [5:0] wRt0,
  output logic [5:0] wRt1,
  output logic [5:0] wRt2,
  output logic       wrfwr0,
  output logic       wrfwr1,
  output logic       wrfwr2,
  output Value       wres0,
  output Value       wres1,
  output Value       wres2,
  output logic       we0,
  output logic       we1,
  output logic [5:0] wa0,
  output logic [5:0] wa1,
  output Value       wd0,
  output Value       wd1
);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t state;

  logic xv0, xv1, xv2;
  logic cv0, cv1, cv2;
  logic full_bundle;

  // Highest lane wins on a shared target so the W stage matches forwarding priority.
  assign xv0 = xrfwr0 && (xRt0 != 6'd0);
  assign xv1 = xrfwr1 && (xRt1 != 6'd0);
  assign xv2 = xrfwr2 && (xRt2 != 6'd0);

  assign cv2 = xv2;
  assign cv1 = xv1 && !(xv2 && (xRt2 == xRt1));
  assign cv0 = xv0 && !(xv1 && (xRt1 == xRt0)) && !(xv2 && (xRt2 == xRt0));

  assign full_bundle = wrfwr0 && wrfwr1 && wrfwr2;
  assign stall_o     = (state == RUN) && full_bundle;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      wRt0   <= '0;
      wRt1   <= '0;
      wRt2   <= '0;
      wrfwr0 <= 1'b0;
      wrfwr1 <= 1'b0;
      wrfwr2 <= 1'b0;
      wres0  <= '0;
      wres1  <= '0;
      wres2  <= '0;
    end else begin
      if (!stall_o) begin
        wRt0   <= xRt0;
        wRt1   <= xRt1;
        wRt2   <= xRt2;
        wrfwr0 <= cv0;
        wrfwr1 <= cv1;
        wrfwr2 <= cv2;
        wres0  <= xres0;
        wres1  <= xres1;
        wres2  <= xres2;
      end
      case (state)
        RUN:     if (full_bundle) state <= DRAIN;
        DRAIN:   state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  // DRAIN only ever owes lane 2; in RUN the valid lanes pack onto ports in lane order.
  always_comb begin
    we0 = 1'b0;
    wa0 = '0;
    wd0 = '0;
    we1 = 1'b0;
    wa1 = '0;
    wd1 = '0;
    if (state == DRAIN) begin
      we0 = wrfwr2;
      wa0 = wRt2;
      wd0 = wres2;
    end else if (wrfwr0) begin
      we0 = 1'b1;
      wa0 = wRt0;
      wd0 = wres0;
      if (wrfwr1) begin
        we1 = 1'b1;
        wa1 = wRt1;
        wd1 = wres1;
      end else if (wrfwr2) begin
        we1 = 1'b1;
        wa1 = wRt2;
        wd1 = wres2;
      end
    end else if (wrfwr1) begin
      we0 = 1'b1;
      wa0 = wRt1;
      wd0 = wres1;
      if (wrfwr2) begin
        we1 = 1'b1;
        wa1 = wRt2;
        wd1 = wres2;
      end
    end else if (wrfwr2) begin
      we0 = 1'b1;
      wa0 = wRt2;
      wd0 = wres2;
    end
  end

endmodule

// File: tb/tb_rf_blackwidow_wb_writer.sv
// Self-checking bench for rf_blackwidow_wb_writer: directed scenarios plus a
// randomized run scored against an in-order write queue model.
module tb_rf_blackwidow_wb_writer;
  import rf_blackwidow_pkg::*;

  localparam int NRAND = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] xRt0, xRt1, xRt2;
  logic       xrfwr0, xrfwr1, xrfwr2;
  Value       xres0, xres1, xres2;
  logic       stall_o;
  logic [5:0] wRt0, wRt1, wRt2;
  logic       wrfwr0, wrfwr1, wrfwr2;
  Value       wres0, wres1, wres2;
  logic       we0, we1;
  logic [5:0] wa0, wa1;
  Value       wd0, wd1;
  logic [2:0] wv;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [5:0] rt;
    Value       val;
  } wr_t;

  wr_t expq[$];

  assign wv = {wrfwr2, wrfwr1, wrfwr0};

  always #5 clk = ~clk;

  rf_blackwidow_wb_writer dut (
    .clk(clk), .rst(rst),
    .xRt0(xRt0), .xRt1(xRt1), .xRt2(xRt2),
    .xrfwr0(xrfwr0), .xrfwr1(xrfwr1), .xrfwr2(xrfwr2),
    .xres0(xres0), .xres1(xres1), .xres2(xres2),
    .stall_o(stall_o),
    .wRt0(wRt0), .wRt1(wRt1), .wRt2(wRt2),
    .wrfwr0(wrfwr0), .wrfwr1(wrfwr1), .wrfwr2(wrfwr2),
    .wres0(wres0), .wres1(wres1), .wres2(wres2),
    .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1)
  );

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  // A lane survives if it asks to write a nonzero register that no later lane also writes.
  function automatic logic [2:0] canon_mask(input logic [2:0] wr, input logic [5:0] r0, r1, r2);
    logic [5:0] rt [3];
    logic [2:0] m;
    rt[0] = r0;
    rt[1] = r1;
    rt[2] = r2;
    m = '0;
    for (int i = 0; i < 3; i++) begin
      m[i] = wr[i] && (rt[i] != 6'd0);
      for (int j = i + 1; j < 3; j++)
        if (wr[j] && rt[j] == rt[i]) m[i] = 1'b0;
    end
    return m;
  endfunction

  task automatic push_expected(input logic [2:0] wr, input logic [5:0] r0, r1, r2,
                               input Value v0, v1, v2);
    logic [2:0] m;
    m = canon_mask(wr, r0, r1, r2);
    if (m[0]) expq.push_back('{rt: r0, val: v0});
    if (m[1]) expq.push_back('{rt: r1, val: v1});
    if (m[2]) expq.push_back('{rt: r2, val: v2});
  endtask

  task automatic drive_bundle(input logic [2:0] wr, input logic [5:0] r0, r1, r2,
                              input Value v0, v1, v2);
    {xrfwr2, xrfwr1, xrfwr0} = wr;
    xRt0 = r0;
    xRt1 = r1;
    xRt2 = r2;
    xres0 = v0;
    xres1 = v1;
    xres2 = v2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_bundle(3'b111, 6'd1, 6'd2, 6'd3, {$urandom, $urandom}, 64'h5, 64'h6);
    tick();
    tick();
    total++;
    if (wv !== 3'b000) begin bad++; $display("[TB] FAIL reset_wrfwr: got %b want 000", wv); end
    total++;
    if ({wRt0, wRt1, wRt2} !== 18'd0) begin bad++; $display("[TB] FAIL reset_wRt: got %0h want 0", {wRt0, wRt1, wRt2}); end
    total++;
    if ({wres0, wres1, wres2} !== 192'd0) begin bad++; $display("[TB] FAIL reset_wres: got %0h want 0", {wres0, wres1, wres2}); end
    total++;
    if ({we0, we1, stall_o} !== 3'b000) begin bad++; $display("[TB] FAIL reset_ports: got %b want 000", {we0, we1, stall_o}); end
    drive_bundle(3'b000, 6'd0, 6'd0, 6'd0, 64'h0, 64'h0, 64'h0);
    rst = 1'b0;
    tick();
    total++;
    if ({we0, we1, stall_o, wv} !== 6'd0) begin bad++; $display("[TB] FAIL post_reset_idle: got %b want 000000", {we0, we1, stall_o, wv}); end
  endtask

  task automatic test_two_writes();
    drive_bundle(3'b110, 6'd0, 6'd5, 6'd7, 64'h0, 64'h11, 64'h22);
    tick();
    drive_bundle(3'b000, 6'd0, 6'd0, 6'd0, 64'h0, 64'h0, 64'h0);
    total++;
    if ({we0, wa0, wd0} !== {1'b1, 6'd5, 64'h11}) begin bad++; $display("[TB] FAIL two_port0: got we=%b wa=%0d wd=%0h want we=1 wa=5 wd=11", we0, wa0, wd0); end
    total++;
    if ({we1, wa1, wd1} !== {1'b1, 6'd7, 64'h22}) begin bad++; $display("[TB] FAIL two_port1: got we=%b wa=%0d wd=%0h want we=1 wa=7 wd=22", we1, wa1, wd1); end
    total++;
    if (stall_o !== 1'b0) begin bad++; $display("[TB] FAIL two_stall: got %b want 0", stall_o); end
    tick();
  endtask

  task automatic test_three_writes();
    drive_bundle(3'b111, 6'd3, 6'd4, 6'd6, 64'hA, 64'hB, 64'hC);
    tick();
    total++;
    if ({we0, wa0, wd0, we1, wa1, wd1} !== {1'b1, 6'd3, 64'hA, 1'b1, 6'd4, 64'hB}) begin
      bad++; $display("[TB] FAIL three_first: got %0d:%0h/%0d:%0h want 3:a/4:b", wa0, wd0, wa1, wd1);
    end
    total++;
    if (stall_o !== 1'b1) begin bad++; $display("[TB] FAIL three_stall: got %b want 1", stall_o); end
    drive_bundle(3'b001, 6'd8, 6'd0, 6'd0, 64'h55, 64'h0, 64'h0);
    tick();
    total++;
    if ({we0, wa0, wd0, we1} !== {1'b1, 6'd6, 64'hC, 1'b0}) begin
      bad++; $display("[TB] FAIL three_drain: got we0=%b wa0=%0d wd0=%0h we1=%b want 1 6 c 0", we0, wa0, wd0, we1);
    end
    total++;
    if ({stall_o, wv} !== 4'b0111) begin bad++; $display("[TB] FAIL three_drain_flags: got %b want 0111", {stall_o, wv}); end
    tick();
    drive_bundle(3'b000, 6'd0, 6'd0, 6'd0, 64'h0, 64'h0, 64'h0);
    total++;
    if ({we0, wa0, wd0, we1, stall_o} !== {1'b1, 6'd8, 64'h55, 1'b0, 1'b0}) begin
      bad++; $display("[TB] FAIL three_next: got we0=%b wa0=%0d wd0=%0h we1=%b stall=%b want 1 8 55 0 0", we0, wa0, wd0, we1, stall_o);
    end
    tick();
  endtask

  task automatic test_collapse();
    drive_bundle(3'b111, 6'd9, 6'd9, 6'd9, 64'h1, 64'h2, 64'h3);
    tick();
    drive_bundle(3'b000, 6'd0, 6'd0, 6'd0, 64'h0, 64'h0, 64'h0);
    total++;
    if (wv !== 3'b100) begin bad++; $display("[TB] FAIL collapse_wrfwr: got %b want 100", wv); end
    total++;
    if ({we0, wa0, wd0, we1, stall_o} !== {1'b1, 6'd9, 64'h3, 1'b0, 1'b0}) begin
      bad++; $display("[TB] FAIL collapse_write: got we0=%b wa0=%0d wd0=%0h we1=%b stall=%b want 1 9 3 0 0", we0, wa0, wd0, we1, stall_o);
    end
    tick();
  endtask

  task automatic test_r0_suppress();
    drive_bundle(3'b011, 6'd0, 6'd2, 6'd0, 64'hFF, 64'h5, 64'h0);
    tick();
    drive_bundle(3'b000, 6'd0, 6'd0, 6'd0, 64'h0, 64'h0, 64'h0);
    total++;
    if (wv !== 3'b010) begin bad++; $display("[TB] FAIL r0_wrfwr: got %b want 010", wv); end
    total++;
    if ({we0, wa0, wd0, we1} !== {1'b1, 6'd2, 64'h5, 1'b0}) begin
      bad++; $display("[TB] FAIL r0_write: got we0=%b wa0=%0d wd0=%0h we1=%b want 1 2 5 0", we0, wa0, wd0, we1);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [5:0] base [4];
    Value vals [4][3];
    int seen;
    wr_t w;
    seen = 0;
    expq.delete();
    for (int b = 0; b < 4; b++) begin
      base[b] = 6'($urandom_range(1, 61));
      for (int l = 0; l < 3; l++) vals[b][l] = {$urandom, $urandom};
      push_expected(3'b111, base[b], base[b] + 6'd1, base[b] + 6'd2, vals[b][0], vals[b][1], vals[b][2]);
    end
    drive_bundle(3'b111, base[0], base[0] + 6'd1, base[0] + 6'd2, vals[0][0], vals[0][1], vals[0][2]);
    for (int j = 0; j < 8; j++) begin
      tick();
      total++;
      if (stall_o !== ((j % 2) == 0)) begin bad++; $display("[TB] FAIL b2b_stall[%0d]: got %b want %b", j, stall_o, (j % 2) == 0); end
      total++;
      if (we0 && we1 && wa0 == wa1) begin bad++; $display("[TB] FAIL b2b_conflict[%0d]: got wa0=%0d wa1=%0d want distinct", j, wa0, wa1); end
      if (we0) begin
        total++;
        seen++;
        if (expq.size() == 0) begin bad++; $display("[TB] FAIL b2b_extra0[%0d]: got wa=%0d want none", j, wa0); end
        else begin
          w = expq.pop_front();
          if ({wa0, wd0} !== {w.rt, w.val}) begin bad++; $display("[TB] FAIL b2b_port0[%0d]: got %0d:%0h want %0d:%0h", j, wa0, wd0, w.rt, w.val); end
        end
      end
      if (we1) begin
        total++;
        seen++;
        if (expq.size() == 0) begin bad++; $display("[TB] FAIL b2b_extra1[%0d]: got wa=%0d want none", j, wa1); end
        else begin
          w = expq.pop_front();
          if ({wa1, wd1} !== {w.rt, w.val}) begin bad++; $display("[TB] FAIL b2b_port1[%0d]: got %0d:%0h want %0d:%0h", j, wa1, wd1, w.rt, w.val); end
        end
      end
      if ((j % 2) == 0) begin
        if (j / 2 + 1 < 4)
          drive_bundle(3'b111, base[j/2+1], base[j/2+1] + 6'd1, base[j/2+1] + 6'd2,
                       vals[j/2+1][0], vals[j/2+1][1], vals[j/2+1][2]);
        else
          drive_bundle(3'b000, 6'd0, 6'd0, 6'd0, 64'h0, 64'h0, 64'h0);
      end
    end
    total++;
    if (seen != 12 || expq.size() != 0) begin bad++; $display("[TB] FAIL b2b_count: got %0d writes, %0d left want 12, 0", seen, expq.size()); end
    tick();
  endtask

  task automatic test_reset_in_drain();
    drive_bundle(3'b111, 6'd20, 6'd21, 6'd22, 64'h1, 64'h2, 64'h3);
    tick();
    tick();
    rst = 1'b1;
    drive_bundle(3'b111, 6'd30, 6'd31, 6'd32, 64'h7, 64'h8, 64'h9);
    tick();
    total++;
    if ({we0, we1, stall_o, wv} !== 6'd0) begin bad++; $display("[TB] FAIL drain_reset: got %b want 000000", {we0, we1, stall_o, wv}); end
    rst = 1'b0;
    drive_bundle(3'b011, 6'd10, 6'd11, 6'd0, 64'hAA, 64'hBB, 64'h0);
    tick();
    drive_bundle(3'b000, 6'd0, 6'd0, 6'd0, 64'h0, 64'h0, 64'h0);
    total++;
    if ({we0, wa0, wd0, we1, wa1, wd1} !== {1'b1, 6'd10, 64'hAA, 1'b1, 6'd11, 64'hBB}) begin
      bad++; $display("[TB] FAIL drain_reset_run: got %b:%0d:%0h %b:%0d:%0h want 1:10:aa 1:11:bb", we0, wa0, wd0, we1, wa1, wd1);
    end
    tick();
  endtask

  task automatic test_random();
    logic       exp_stall, will_cap;
    logic [2:0] exp_mask, new_mask;
    logic [2:0] bwr;
    logic [5:0] br0, br1, br2;
    Value       bv0, bv1, bv2;
    wr_t        w;
    int         sent;
    exp_stall = 1'b0;
    exp_mask = 3'b000;
    new_mask = 3'b000;
    expq.delete();
    bwr = 3'($urandom);
    br0 = 6'($urandom_range(0, 7));
    br1 = 6'($urandom_range(0, 7));
    br2 = 6'($urandom_range(0, 7));
    bv0 = {$urandom, $urandom};
    bv1 = {$urandom, $urandom};
    bv2 = {$urandom, $urandom};
    drive_bundle(bwr, br0, br1, br2, bv0, bv1, bv2);
    sent = 1;
    for (int cyc = 0; cyc < 3 * NRAND + 6; cyc++) begin
      will_cap = !exp_stall;
      if (will_cap) begin
        new_mask = canon_mask(bwr, br0, br1, br2);
        push_expected(bwr, br0, br1, br2, bv0, bv1, bv2);
      end
      tick();
      if (will_cap) begin
        exp_mask = new_mask;
        exp_stall = (new_mask == 3'b111);
      end else begin
        exp_stall = 1'b0;
      end
      total++;
      if (stall_o !== exp_stall) begin bad++; $display("[TB] FAIL rand_stall[%0d]: got %b want %b", cyc, stall_o, exp_stall); end
      total++;
      if (wv !== exp_mask) begin bad++; $display("[TB] FAIL rand_wrfwr[%0d]: got %b want %b", cyc, wv, exp_mask); end
      total++;
      if (we1 && !we0) begin bad++; $display("[TB] FAIL rand_order[%0d]: got we0=0 we1=1 want port0 used first", cyc); end
      total++;
      if (we0 && we1 && wa0 == wa1) begin bad++; $display("[TB] FAIL rand_conflict[%0d]: got wa0=%0d wa1=%0d want distinct", cyc, wa0, wa1); end
      if (we0) begin
        total++;
        if (expq.size() == 0) begin bad++; $display("[TB] FAIL rand_extra0[%0d]: got wa=%0d want none", cyc, wa0); end
        else begin
          w = expq.pop_front();
          if ({wa0, wd0} !== {w.rt, w.val}) begin bad++; $display("[TB] FAIL rand_port0[%0d]: got %0d:%0h want %0d:%0h", cyc, wa0, wd0, w.rt, w.val); end
        end
      end
      if (we1) begin
        total++;
        if (expq.size() == 0) begin bad++; $display("[TB] FAIL rand_extra1[%0d]: got wa=%0d want none", cyc, wa1); end
        else begin
          w = expq.pop_front();
          if ({wa1, wd1} !== {w.rt, w.val}) begin bad++; $display("[TB] FAIL rand_port1[%0d]: got %0d:%0h want %0d:%0h", cyc, wa1, wd1, w.rt, w.val); end
        end
      end
      if (will_cap) begin
        if (sent < NRAND) begin
          bwr = 3'($urandom);
          br0 = 6'($urandom_range(0, 7));
          br1 = 6'($urandom_range(0, 7));
          br2 = 6'($urandom_range(0, 7));
          bv0 = {$urandom, $urandom};
          bv1 = {$urandom, $urandom};
          bv2 = {$urandom, $urandom};
          sent++;
        end else begin
          bwr = 3'b000;
          br0 = 6'd0;
          br1 = 6'd0;
          br2 = 6'd0;
          bv0 = '0;
          bv1 = '0;
          bv2 = '0;
        end
        drive_bundle(bwr, br0, br1, br2, bv0, bv1, bv2);
      end
    end
    total++;
    if (expq.size() != 0) begin bad++; $display("[TB] FAIL rand_leftover: got %0d unwritten want 0", expq.size()); end
  endtask

  initial begin
    drive_bundle(3'b000, 6'd0, 6'd0, 6'd0, 64'h0, 64'h0, 64'h0);
    test_reset();
    test_two_writes();
    test_three_writes();
    test_collapse();
    test_r0_suppress();
    test_back_to_back();
    test_reset_in_drain();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
